// File: rtl/pll_mcu_rst_seq.sv
// pll_mcu_rst_seq: PLL reset / lock qualification sequencer gating the MCU reset request.
// Optional retry limit (FAIL state) enabled by defining PLL_MCU_RST_RETRY_LIMIT_EN.
module pll_mcu_rst_seq #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int STABLE_CYCLES       = 1024,
  parameter int MAX_RETRIES         = 7
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       sw_rst_req,
  input  logic       lock_lost_clr,
  output logic       pll_rst,
  output logic       mcu_rst_n,
  output logic [2:0] state,
  output logic [3:0] retry_cnt,
  output logic       lock_lost,
  output logic       fail
);
`ifdef PLL_MCU_RST_RETRY_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif
  localparam int MAXC = (LOCK_TIMEOUT_CYCLES > STABLE_CYCLES)
                        ? ((LOCK_TIMEOUT_CYCLES > PLL_RST_CYCLES) ? LOCK_TIMEOUT_CYCLES : PLL_RST_CYCLES)
                        : ((STABLE_CYCLES > PLL_RST_CYCLES) ? STABLE_CYCLES : PLL_RST_CYCLES);
  localparam int CW = $clog2(MAXC + 1);
  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;
  state_t          st, st_nx;
  logic [1:0]      sync;
  logic            lk_s;
  logic [CW-1:0]   cnt;
  logic [3:0]      rc_nx, rc_inc;
  logic            ll_set;
  assign lk_s   = sync[1];
  assign state  = st;
  assign rc_inc = (retry_cnt == 4'hf) ? retry_cnt : retry_cnt + 4'd1;
  always_comb begin
    st_nx  = st;
    rc_nx  = retry_cnt;
    ll_set = 1'b0;
    if (sw_rst_req) begin
      st_nx = PLL_RST;
      rc_nx = '0;
    end else begin
      case (st)
        PLL_RST:   st_nx = (cnt == CW'(PLL_RST_CYCLES - 1)) ? WAIT_LOCK : PLL_RST;
        WAIT_LOCK: begin
          if (lk_s) st_nx = STABLE;
          else if (cnt == CW'(LOCK_TIMEOUT_CYCLES - 1)) begin
            rc_nx = rc_inc;
            st_nx = (LIMIT_EN && retry_cnt == 4'(MAX_RETRIES - 1)) ? FAIL : PLL_RST;
          end
        end
        STABLE: begin
          if (!lk_s) st_nx = WAIT_LOCK;
          else if (cnt == CW'(STABLE_CYCLES - 1)) begin
            st_nx = RUN;
            rc_nx = '0;
          end
        end
        RUN: begin
          st_nx  = lk_s ? RUN : PLL_RST;
          ll_set = !lk_s;
        end
        default: st_nx = st;
      endcase
    end
  end
  // Counter restarts on every state entry, including a software restart from PLL_RST.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      sync      <= '0;
      st        <= PLL_RST;
      cnt       <= '0;
      retry_cnt <= '0;
      lock_lost <= 1'b0;
      pll_rst   <= 1'b1;
      mcu_rst_n <= 1'b0;
      fail      <= 1'b0;
    end else begin
      sync      <= {sync[0], pll_locked};
      st        <= st_nx;
      cnt       <= (st_nx != st || sw_rst_req) ? '0 : cnt + CW'(1);
      retry_cnt <= rc_nx;
      lock_lost <= ll_set | (lock_lost & ~lock_lost_clr);
      pll_rst   <= (st_nx == PLL_RST) || (st_nx == FAIL);
      mcu_rst_n <= (st_nx == RUN);
      fail      <= LIMIT_EN && (st_nx == FAIL);
    end
  end
endmodule
